// File: rtl/uart_pkg.sv
// Constants and helpers shared by the chunked serializer and deserializer.
// Both ends derive the chunk count and its width from here so they stay consistent.
package uart_pkg;

    localparam int P_WIDTH_DEF = 24;
    localparam int S_WIDTH_DEF = 8;

    typedef enum logic {
        ASM_IDLE     = 1'b0,
        ASM_ASSEMBLE = 1'b1
    } asm_state_t;

    function automatic int count_max(input int p_width, input int s_width);
        return p_width / s_width;
    endfunction

    // Width of a counter running 0..cmax-1, never narrower than one bit.
    function automatic int count_width(input int cmax);
        return (cmax <= 2) ? 1 : $clog2(cmax);
    endfunction

    localparam int COUNT_MAX_DEF = count_max(P_WIDTH_DEF, S_WIDTH_DEF);

endpackage

// File: rtl/serial_to_parallel_gap_timer.sv
// Idle-gap detector: counts cycles with run=1 and kick=0; expire is a combinational pulse
// on the TIMEOUT-th such cycle. kick or !run restarts the count. TIMEOUT=0 never expires.
module gap_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic kick,
    output logic expire
);

    localparam int            CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam bit            ENABLED = (TIMEOUT != 0);
    localparam logic [CW-1:0] LAST    = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    assign expire = ENABLED && run && !kick && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || !run || kick || expire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_to_parallel.sv
// Assembles S_WIDTH chunks (MSB chunk first) into a P_WIDTH word; word valid 1 cycle after last chunk.
// Input never stalls; a word completing while the holding register stays full is dropped (sticky overflow).
module serial_to_parallel
    import uart_pkg::*;
#(
    parameter int P_WIDTH = P_WIDTH_DEF,
    parameter int S_WIDTH = S_WIDTH_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [S_WIDTH-1:0] in_data,
    input  logic               out_ready,
    input  logic               ovf_clr,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] out_data,
    output logic               busy,
    output logic               overflow,
    output logic               frame_err
);

    localparam int            CMAX     = count_max(P_WIDTH, S_WIDTH);
    localparam int            CW       = count_width(CMAX);
    localparam int            SH_W     = P_WIDTH - S_WIDTH;
    localparam logic [CW-1:0] LAST_IDX = CW'(CMAX - 1);

    asm_state_t        state;
    logic [CW-1:0]     count;
    logic [SH_W-1:0]   shift;
    logic [P_WIDTH-1:0] word;
    logic              complete, drain, accept, drop, expire;

    assign word     = {shift, in_data};
    assign complete = in_valid && (count == LAST_IDX);
    assign drain    = out_valid && out_ready;
    // A word may land in the same cycle the held one is consumed.
    assign accept   = complete && (!out_valid || drain);
    assign drop     = complete && !accept;

    gap_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .run    (state == ASM_ASSEMBLE),
        .kick   (in_valid),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ASM_IDLE;
            count     <= '0;
            shift     <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= expire;

            if (in_valid) begin
                shift <= word[SH_W-1:0];
                if (complete) begin
                    count <= '0;
                    busy  <= 1'b0;
                    state <= ASM_IDLE;
                end else begin
                    count <= count + CW'(1);
                    busy  <= 1'b1;
                    state <= ASM_ASSEMBLE;
                end
            end else if (expire) begin
                shift <= '0;
                count <= '0;
                busy  <= 1'b0;
                state <= ASM_IDLE;
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= word;
            end else if (drain) begin
                out_valid <= 1'b0;
                out_data  <= '0;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench: dut uses TIMEOUT=4, dut0 uses TIMEOUT=0; both share the same stimulus.
module tb_serial_to_parallel;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        out_ready;
    logic        ovf_clr;

    logic        out_valid,  busy,  overflow,  frame_err;
    logic [23:0] out_data;
    logic        out_valid0, busy0, overflow0, frame_err0;
    logic [23:0] out_data0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_to_parallel #(.P_WIDTH(24), .S_WIDTH(8), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid),
        .out_data(out_data), .busy(busy), .overflow(overflow), .frame_err(frame_err)
    );

    serial_to_parallel #(.P_WIDTH(24), .S_WIDTH(8), .TIMEOUT(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid0),
        .out_data(out_data0), .busy(busy0), .overflow(overflow0), .frame_err(frame_err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chunk(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        logic seen_err;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; ovf_clr = 1'b0;
        tick(); tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  {8'd0, out_data},   32'd0);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_ovf",   {31'd0, overflow},  32'd0);
        check("rst_ferr",  {31'd0, frame_err}, 32'd0);
        rst = 1'b0;

        // Basic assembly
        out_ready = 1'b1;
        chunk(8'hAB); check("basic_busy1", {31'd0, busy}, 32'd1);
        check("basic_novalid", {31'd0, out_valid}, 32'd0);
        chunk(8'hCD); check("basic_busy2", {31'd0, busy}, 32'd1);
        chunk(8'hEF);
        check("basic_valid", {31'd0, out_valid}, 32'd1);
        check("basic_data",  {8'd0, out_data},   32'h00ABCDEF);
        check("basic_busy0", {31'd0, busy},      32'd0);
        idle(1);
        check("basic_drained", {31'd0, out_valid}, 32'd0);
        check("basic_zero",    {8'd0, out_data},   32'd0);

        // Back-pressure and overflow
        out_ready = 1'b0;
        chunk(8'h11); chunk(8'h22); chunk(8'h33);
        check("bp_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data1", {8'd0, out_data},   32'h00112233);
        check("bp_busy_hold", {31'd0, busy},  32'd0);
        chunk(8'h44); check("bp_assemble_while_full", {31'd0, busy}, 32'd1);
        chunk(8'h55); chunk(8'h66);
        check("bp_data_kept", {8'd0, out_data},   32'h00112233);
        check("bp_ovf",       {31'd0, overflow},  32'd1);
        out_ready = 1'b1;
        idle(1);
        check("bp_drain_valid", {31'd0, out_valid}, 32'd0);
        check("bp_ovf_sticky",  {31'd0, overflow},  32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("bp_ovf_clr", {31'd0, overflow}, 32'd0);

        // Drop in the same cycle as ovf_clr keeps overflow set
        out_ready = 1'b0;
        chunk(8'h77); chunk(8'h88); chunk(8'h99);
        chunk(8'h01); chunk(8'h02);
        ovf_clr = 1'b1; chunk(8'h03); ovf_clr = 1'b0;
        check("clr_vs_drop_ovf",  {31'd0, overflow}, 32'd1);
        check("clr_vs_drop_data", {8'd0, out_data},  32'h00778899);
        out_ready = 1'b1; idle(1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("clr_vs_drop_clr", {31'd0, overflow}, 32'd0);

        // Timeout after 4 idle cycles
        chunk(8'h12); chunk(8'h34);
        idle(3);
        check("to_busy_before", {31'd0, busy},      32'd1);
        check("to_ferr_before", {31'd0, frame_err}, 32'd0);
        idle(1);
        check("to_ferr",      {31'd0, frame_err}, 32'd1);
        check("to_busy_after",{31'd0, busy},      32'd0);
        idle(1);
        check("to_ferr_pulse",{31'd0, frame_err}, 32'd0);
        chunk(8'hAA); chunk(8'hBB); chunk(8'hCC);
        check("to_next_valid", {31'd0, out_valid}, 32'd1);
        check("to_next_data",  {8'd0, out_data},   32'h00AABBCC);
        idle(1);

        // Chunk in the would-be expiry cycle is taken instead
        chunk(8'h12); chunk(8'h34);
        idle(3);
        chunk(8'h56);
        check("late_data",  {8'd0, out_data},   32'h00123456);
        check("late_valid", {31'd0, out_valid}, 32'd1);
        check("late_ferr",  {31'd0, frame_err}, 32'd0);
        idle(1);
        check("late_ferr2", {31'd0, frame_err}, 32'd0);

        // Drain and completion in the same cycle
        out_ready = 1'b0;
        chunk(8'h01); chunk(8'h02); chunk(8'h03);
        check("dc_a", {8'd0, out_data}, 32'h00010203);
        chunk(8'h04); chunk(8'h05);
        out_ready = 1'b1;
        chunk(8'h06);
        check("dc_valid", {31'd0, out_valid}, 32'd1);
        check("dc_b",     {8'd0, out_data},   32'h00040506);
        check("dc_ovf",   {31'd0, overflow},  32'd0);
        idle(1);
        check("dc_empty", {31'd0, out_valid}, 32'd0);

        // Reset mid-word
        chunk(8'h12); chunk(8'h34);
        rst = 1'b1; tick(); rst = 1'b0;
        check("mrst_busy",  {31'd0, busy},      32'd0);
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_ferr",  {31'd0, frame_err}, 32'd0);
        seen_err = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_err = seen_err | frame_err;
        end
        check("mrst_no_ferr", {31'd0, seen_err}, 32'd0);
        chunk(8'h9A); chunk(8'hBC); chunk(8'hDE);
        check("mrst_data",  {8'd0, out_data},   32'h009ABCDE);
        check("mrst_valid2",{31'd0, out_valid}, 32'd1);
        idle(1);

        // TIMEOUT=0 instance: long gaps never abort the word
        seen_err = 1'b0;
        chunk(8'h11);
        for (int i = 0; i < 100; i++) begin
            tick();
            seen_err = seen_err | frame_err0;
        end
        check("t0_busy", {31'd0, busy0}, 32'd1);
        chunk(8'h22);
        for (int i = 0; i < 100; i++) begin
            tick();
            seen_err = seen_err | frame_err0;
        end
        chunk(8'h33);
        check("t0_valid", {31'd0, out_valid0}, 32'd1);
        check("t0_data",  {8'd0, out_data0},   32'h00112233);
        check("t0_ferr",  {31'd0, seen_err},   32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
